dcache_controller: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache that serves the core's LW/SW/LB/SB requests.
- Produces the `hit` signal the control unit uses to gate `pc_we`. The core stalls while `hit`=0 on a memory instruction.
- Sits between the datapath's memory port and the multi-cycle main memory.
- Also provides a flush sweep so dirty lines reach main memory after a halt.

---
 rtl/dcache_pkg.sv | 48 ++++
 rtl/dcache_array.sv | 75 +++++++
 rtl/dcache_controller.sv | 189 ++++++++++++++++++
 tb/tb_dcache_controller.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// ---------------------------------------------------------------------------
// dcache_pkg
// Shared types and helpers for the direct-mapped write-back data cache.
//   state_t       controller FSM states
//   addr_tag/addr_index/addr_lane  split a byte address for a given index width
//   extract_byte / merge_byte      little-endian byte lane access within a word
// ---------------------------------------------------------------------------
package dcache_pkg;

    localparam int INDEX_BITS_DEFAULT = 11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WRITEBACK  = 3'd1,
        ST_FILL       = 3'd2,
        ST_FLUSH_SCAN = 3'd3,
        ST_FLUSH_WB   = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    // Tag and index come back right-aligned in 30 bits; callers size-cast
    // them to TAG_BITS / INDEX_BITS.
    function automatic logic [29:0] addr_tag(input logic [31:0] addr, input int index_bits);
        return 30'(addr >> (index_bits + 2));
    endfunction

    function automatic logic [29:0] addr_index(input logic [31:0] addr, input int index_bits);
        return 30'((addr >> 2) & ((32'd1 << index_bits) - 32'd1));
    endfunction

    function automatic logic [1:0] addr_lane(input logic [31:0] addr);
        return 2'(addr & 32'h3);
    endfunction

    // Lane 0 is bits [7:0], lane 3 is bits [31:24].
    function automatic logic [7:0] extract_byte(input logic [31:0] word, input logic [1:0] lane);
        return word[lane*8 +: 8];
    endfunction

    function automatic logic [31:0] merge_byte(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [7:0] b);
        logic [31:0] res;
        res = word;
        res[lane*8 +: 8] = b;
        return res;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// ---------------------------------------------------------------------------
// dcache_array
// Line storage: valid, dirty, tag and one data word per line.
//   clk, rst                  clock, async active-high reset (clears valid/dirty)
//   idx                       line index for both the read and the write port
//   rd_valid/rd_dirty/rd_tag/rd_data   asynchronous read of line idx
//   data_we, wr_data          write the data word
//   tag_we, wr_tag            write the tag and mark the line valid
//   dirty_we, wr_dirty        write the dirty bit
// ---------------------------------------------------------------------------
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEFAULT,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  data_we,
    input  logic [31:0]           wr_data,
    input  logic                  tag_we,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic                  dirty_we,
    input  logic                  wr_dirty
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q, valid_d;
    logic [LINES-1:0]    dirty_q, dirty_d;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_mem[idx];
    assign rd_data  = data_mem[idx];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (tag_we) begin
            valid_d[idx] = 1'b1;
        end
        if (dirty_we) begin
            dirty_d[idx] = wr_dirty;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag/data contents are meaningless while valid=0, so they carry no reset.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[idx] <= wr_data;
        end
        if (tag_we) begin
            tag_mem[idx] <= wr_tag;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// ---------------------------------------------------------------------------
// dcache_controller
// Direct-mapped, write-back, write-allocate data cache with a flush sweep.
//   clk, reset             clock, async active-high reset
//   req/we/is_byte/addr/wdata   core request (LW/SW/LB/SB)
//   rdata, hit             load data (byte zero-extended) and request-done
//   flush, flush_done      level flush request and sweep-complete flag
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready   main memory port
//   dbg_state              current controller state for observation
//
// Handshakes: the core holds req with stable addr/we/is_byte/wdata until it
// sees hit=1; the request is consumed at the rising edge where hit=1.
// The cache holds mem_req with stable mem_we/mem_addr/mem_wdata until a
// rising edge where mem_ready=1; that edge completes the transaction.
// ---------------------------------------------------------------------------
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEFAULT,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        is_byte,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    input  logic        flush,
    output logic        flush_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output state_t      dbg_state
);

    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] cnt_q, cnt_d;

    logic [TAG_BITS-1:0]   a_tag;
    logic [INDEX_BITS-1:0] a_idx;
    logic [1:0]            a_lane;
    logic [INDEX_BITS-1:0] arr_idx;
    logic                  in_flush;
    logic                  line_hit;

    logic                  rd_valid, rd_dirty;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [31:0]           rd_data;
    logic                  data_we, tag_we, dirty_we, wr_dirty;
    logic [31:0]           wr_data;

    assign a_tag    = TAG_BITS'(addr_tag(addr, INDEX_BITS));
    assign a_idx    = INDEX_BITS'(addr_index(addr, INDEX_BITS));
    assign a_lane   = addr_lane(addr);
    // The sweep walks the array with its own counter; everything else uses addr.
    assign in_flush = (state_q == ST_FLUSH_SCAN) || (state_q == ST_FLUSH_WB);
    assign arr_idx  = in_flush ? cnt_q : a_idx;
    assign line_hit = rd_valid && (rd_tag == a_tag);
    assign dbg_state = state_q;

    dcache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk      (clk),
        .rst      (reset),
        .idx      (arr_idx),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .data_we  (data_we),
        .wr_data  (wr_data),
        .tag_we   (tag_we),
        .wr_tag   (a_tag),
        .dirty_we (dirty_we),
        .wr_dirty (wr_dirty)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hit        = 1'b0;
        rdata      = '0;
        flush_done = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        data_we    = 1'b0;
        wr_data    = '0;
        tag_we     = 1'b0;
        dirty_we   = 1'b0;
        wr_dirty   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_FLUSH_SCAN;
                    cnt_d   = '0;
                end else if (req) begin
                    if (line_hit) begin
                        hit   = 1'b1;
                        rdata = is_byte ? {24'd0, extract_byte(rd_data, a_lane)} : rd_data;
                        if (we) begin
                            data_we  = 1'b1;
                            wr_data  = is_byte ? merge_byte(rd_data, a_lane, wdata[7:0]) : wdata;
                            dirty_we = 1'b1;
                            wr_dirty = 1'b1;
                        end
                    end else if (rd_valid && rd_dirty) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {rd_tag, a_idx, 2'b00};
                mem_wdata = rd_data;
                if (mem_ready) begin
                    dirty_we = 1'b1;
                    state_d  = ST_FILL;
                end
            end
            ST_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {a_tag, a_idx, 2'b00};
                // Only install here; a pending store merges on the IDLE hit cycle.
                if (mem_ready) begin
                    data_we  = 1'b1;
                    wr_data  = mem_rdata;
                    tag_we   = 1'b1;
                    dirty_we = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_FLUSH_SCAN: begin
                if (rd_valid && rd_dirty) begin
                    state_d = ST_FLUSH_WB;
                end else if (&cnt_q) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FLUSH_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {rd_tag, cnt_q, 2'b00};
                mem_wdata = rd_data;
                if (mem_ready) begin
                    dirty_we = 1'b1;
                    if (&cnt_q) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_FLUSH_SCAN;
                    end
                end
            end
            ST_DONE: begin
                flush_done = flush;
                if (!flush) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
`timescale 1ns/1ps
module tb_dcache_controller;
    import dcache_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0, we = 1'b0, is_byte = 1'b0, flush = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        hit, flush_done, mem_req, mem_we, mem_ready;
    state_t      dbg_state;

    logic        auto_mem = 1'b0;
    logic        auto_ready = 1'b0, man_ready = 1'b0;
    logic [31:0] auto_rdata = '0, man_rdata = '0;
    assign mem_ready = auto_mem ? auto_ready : man_ready;
    assign mem_rdata = auto_mem ? auto_rdata : man_rdata;

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .is_byte(is_byte),
        .addr(addr), .wdata(wdata), .rdata(rdata), .hit(hit),
        .flush(flush), .flush_done(flush_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_pass  = 0;
    logic [64:0] exp_q[$];   // {we, word address, write data (0 for fills)}

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Architectural memory view plus per-line presence/dirty/tag bookkeeping.
    logic [31:0] arch    [logic [31:0]];
    logic [31:0] backing [logic [31:0]];
    bit          m_valid [2048];
    bit          m_dirty [2048];
    int          m_tag   [2048];

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction
    function automatic logic [31:0] arch_rd(input logic [31:0] a);
        return arch.exists(a) ? arch[a] : mem_init(a);
    endfunction
    function automatic logic [31:0] backing_rd(input logic [31:0] a);
        return backing.exists(a) ? backing[a] : mem_init(a);
    endfunction

    // ---------------- randomized memory responder ----------------
    bit in_txn = 0;
    int lat = 0;
    always @(negedge clk) begin
        if (!auto_mem) begin
            in_txn = 0;
            auto_ready = 1'b0;
        end else begin
            if (auto_ready) in_txn = 0;
            auto_ready = 1'b0;
            if (!mem_req) begin
                in_txn = 0;
            end else begin
                if (!in_txn) begin
                    bit pending;
                    logic [64:0] e;
                    in_txn  = 1;
                    lat     = $urandom_range(0, 3);
                    pending = (exp_q.size() != 0);
                    chk("txn_expected", pending, 1'b1);
                    if (pending) begin
                        e = exp_q.pop_front();
                        chk("txn", {mem_we, mem_addr, (mem_we ? mem_wdata : 32'h0)}, e);
                    end
                    if (mem_we) backing[mem_addr] = mem_wdata;
                end
                if (lat == 0) begin
                    auto_ready = 1'b1;
                    auto_rdata = mem_we ? 32'h0 : backing_rd(mem_addr);
                end else begin
                    lat--;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One cycle: drive just after the rising edge, sample on the falling edge.
    task automatic step(input logic r, input logic w, input logic b,
                        input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        req = r; we = w; is_byte = b; addr = a; wdata = d;
        @(negedge clk);
    endtask

    task automatic hold();
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    // Manual memory: wait for a transaction, check it, answer after lat cycles.
    task automatic serve(input string nm, input logic ew, input logic [31:0] ea,
                         input logic [31:0] ewd, input logic [31:0] rd, input int lt,
                         output int waited);
        waited = 0;
        for (int n = 0; n < 20; n++) begin
            hold();
            waited++;
            if (mem_req) break;
        end
        chk({nm, "_req"}, mem_req, 1'b1);
        chk({nm, "_we"}, mem_we, ew);
        chk({nm, "_addr"}, mem_addr, ea);
        if (ew) chk({nm, "_wdata"}, mem_wdata, ewd);
        for (int i = 0; i < lt; i++) begin
            chk({nm, "_busy_hit"}, hit, 1'b0);
            hold();
            chk({nm, "_held"}, mem_req, 1'b1);
        end
        man_ready = 1'b1;
        man_rdata = rd;
        @(posedge clk); #1;
        man_ready = 1'b0;
        man_rdata = '0;
        @(negedge clk);
    endtask

    // Random op against the model.
    task automatic do_op(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d);
        int          ix, tg, n, sh;
        bit          exp_hit, got;
        logic [31:0] wa, oa, cur, nw;
        ix = int'((a >> 2) & 32'h7FF);
        tg = int'(a >> 13);
        wa = a & 32'hFFFF_FFFC;
        sh = int'(a & 32'h3) * 8;
        exp_hit = m_valid[ix] && (m_tag[ix] == tg);
        if (!exp_hit) begin
            if (m_valid[ix] && m_dirty[ix]) begin
                oa = (32'(m_tag[ix]) << 13) | (32'(ix) << 2);
                exp_q.push_back({1'b1, oa, arch_rd(oa)});
            end
            exp_q.push_back({1'b0, wa, 32'h0});
            m_valid[ix] = 1;
            m_tag[ix]   = tg;
            m_dirty[ix] = 0;
        end
        step(1'b1, w, b, a, d);
        chk("first_cycle_hit", hit, exp_hit);
        got = hit;
        n = 0;
        while (!got && n < 60) begin
            hold();
            got = hit;
            n++;
        end
        chk("op_completes", got, 1'b1);
        cur = arch_rd(wa);
        if (!w) begin
            chk("load_rdata", rdata, b ? ((cur >> sh) & 32'hFF) : cur);
        end else begin
            nw = b ? ((cur & ~(32'hFF << sh)) | ((d & 32'hFF) << sh)) : d;
            arch[wa] = nw;
            m_dirty[ix] = 1;
        end
        step(1'b0, 1'b0, 1'b0, a, d);
        chk("txn_drained", exp_q.size(), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        r, w, b;
        logic [31:0] a, d;
        logic        exp_hit, chk_rd;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs[8];

    int waited, wr_cnt, req_cycles;
    bit done;
    logic [31:0] wr_addr[4], wr_data[4];
    int ix_set[4] = '{0, 1, 2, 2047};

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h12345678, 1'b1, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0,        1'b1, 1'b1, 32'h12345678};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h41, 32'h000000AB, 1'b1, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0,        1'b1, 1'b1, 32'h1234AB78};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h41, 32'h0,        1'b1, 1'b1, 32'h000000AB};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h43, 32'h0,        1'b1, 1'b1, 32'h00000012};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h40, 32'h0,        1'b1, 1'b1, 32'h00000078};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h40, 32'h0,        1'b0, 1'b0, 32'h0};

        // ---- reset values ----
        @(negedge clk);
        chk("rst_hit", hit, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_state", dbg_state, ST_IDLE);
        #3 reset = 1'b0;
        @(negedge clk);
        chk("idle_outputs", {hit, flush_done, mem_req, mem_we, mem_addr, mem_wdata, rdata}, '0);

        // ---- load miss: fill 0x40, ready after 3 cycles ----
        step(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        chk("miss_hit", hit, 1'b0);
        serve("fill40", 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 2, waited);
        chk("fill40_hit", hit, 1'b1);
        chk("fill40_rdata", rdata, 32'hDEADBEEF);

        // ---- store / byte hits from the table ----
        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].w, vecs[i].b, vecs[i].a, vecs[i].d);
            chk($sformatf("vec%0d_hit", i), hit, vecs[i].exp_hit);
            chk($sformatf("vec%0d_no_mem", i), mem_req, 1'b0);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
        end

        // ---- dirty conflict: write-back 0x40 then fill 0x2040 ----
        step(1'b1, 1'b0, 1'b0, 32'h2040, 32'h0);
        chk("conf_miss", hit, 1'b0);
        serve("conf_wb", 1'b1, 32'h40, 32'h1234AB78, 32'h0, 0, waited);
        serve("conf_fill", 1'b0, 32'h2040, 32'h0, 32'hCAFEF00D, 1, waited);
        chk("conf_hit", hit, 1'b1);
        chk("conf_rdata", rdata, 32'hCAFEF00D);

        // ---- make two dirty lines: 0x2040 (hit) and 0x80 (store miss) ----
        step(1'b1, 1'b1, 1'b0, 32'h2040, 32'h55AA55AA);
        chk("sw2040_hit", hit, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h80, 32'h0BADF00D);
        chk("sw80_miss", hit, 1'b0);
        serve("fill80", 1'b0, 32'h80, 32'h0, 32'h11111111, 1, waited);
        chk("sw80_hit", hit, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // ---- flush with two dirty lines ----
        @(posedge clk); #1 flush = 1'b1;
        wr_cnt = 0; done = 0;
        for (int c = 0; c < 5000 && !done; c++) begin
            @(negedge clk);
            man_ready = 1'b0;
            if (flush_done) begin
                done = 1;
            end else if (mem_req) begin
                if (wr_cnt < 4) begin
                    wr_addr[wr_cnt] = mem_we ? mem_addr : 32'hFFFF_FFFF;
                    wr_data[wr_cnt] = mem_wdata;
                end
                wr_cnt++;
                man_ready = 1'b1;
            end
        end
        man_ready = 1'b0;
        chk("flush1_done", done, 1'b1);
        chk("flush1_writes", wr_cnt, 2);
        chk("flush1_addr0", wr_addr[0], 32'h2040);
        chk("flush1_data0", wr_data[0], 32'h55AA55AA);
        chk("flush1_addr1", wr_addr[1], 32'h80);
        chk("flush1_data1", wr_data[1], 32'h0BADF00D);
        for (int i = 0; i < 3; i++) begin
            hold();
            chk("flush_done_held", {flush_done, mem_req}, 2'b10);
        end
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_done_drop", flush_done, 1'b0);

        // ---- second flush: nothing dirty, no memory traffic ----
        @(posedge clk); #1 flush = 1'b1;
        req_cycles = 0; done = 0;
        for (int c = 0; c < 5000 && !done; c++) begin
            @(negedge clk);
            if (mem_req) req_cycles++;
            if (flush_done) done = 1;
        end
        chk("flush2_done", done, 1'b1);
        chk("flush2_mem_cycles", req_cycles, 0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);

        // ---- flush kept lines valid ----
        step(1'b1, 1'b0, 1'b0, 32'h80, 32'h0);
        chk("post_flush_hit", hit, 1'b1);
        chk("post_flush_rdata", rdata, 32'h0BADF00D);
        chk("post_flush_no_mem", mem_req, 1'b0);

        // ---- reset pulse mid-FILL ----
        step(1'b1, 1'b0, 1'b0, 32'h3040, 32'h0);
        chk("rfill_miss", hit, 1'b0);
        hold();
        chk("rfill_in_fill", mem_req, 1'b1);
        #1 reset = 1'b1;
        #1 chk("rfill_async_drop", mem_req, 1'b0);
        req = 1'b0;
        #1 reset = 1'b0;
        step(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        chk("post_rst_miss", hit, 1'b0);
        serve("post_rst_fill", 1'b0, 32'h40, 32'h0, 32'h77777777, 0, waited);
        chk("miss_penalty_cycles", waited, 1);
        chk("post_rst_hit", hit, 1'b1);
        chk("post_rst_rdata", rdata, 32'h77777777);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // ---- randomized phase against the model ----
        @(posedge clk); #1 reset = 1'b1;
        #2 reset = 1'b0;
        arch.delete();
        backing.delete();
        exp_q.delete();
        foreach (m_valid[i]) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
            m_tag[i]   = 0;
        end
        auto_mem = 1'b1;
        for (int k = 0; k < 300; k++) begin
            logic        w, b;
            logic [31:0] a;
            int          tg, ix, ln;
            tg = $urandom_range(0, 3);
            ix = ix_set[$urandom_range(0, 3)];
            w  = 1'($urandom_range(0, 1));
            b  = 1'($urandom_range(0, 1));
            ln = b ? $urandom_range(0, 3) : 0;
            a  = (32'(tg) << 13) | (32'(ix) << 2) | 32'(ln);
            do_op(w, b, a, $urandom);
        end

        // ---- final flush: dirty lines written back in index order ----
        foreach (ix_set[i]) begin
            int ix;
            logic [31:0] oa;
            ix = ix_set[i];
            if (m_valid[ix] && m_dirty[ix]) begin
                oa = (32'(m_tag[ix]) << 13) | (32'(ix) << 2);
                exp_q.push_back({1'b1, oa, arch_rd(oa)});
                m_dirty[ix] = 0;
            end
        end
        @(posedge clk); #1 flush = 1'b1;
        done = 0;
        for (int c = 0; c < 10000 && !done; c++) begin
            @(negedge clk);
            if (flush_done) done = 1;
        end
        chk("flush3_done", done, 1'b1);
        chk("flush3_drained", exp_q.size(), 0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        foreach (arch[k]) begin
            chk($sformatf("mem_%h", k), backing_rd(k), arch[k]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
